// File: rtl/reflex_pkg.sv
// rtl/reflex_pkg.sv - shared torque types, drive state encodings and saturate/abs helpers
package reflex_pkg;

    localparam int TORQUE_W = 16;

    typedef enum logic [1:0] {
        DRV_IDLE     = 2'd0,
        DRV_RUN      = 2'd1,
        DRV_DEADTIME = 2'd2,
        DRV_FAULT    = 2'd3
    } drv_state_e;

    // Clamp a 17-bit signed value into [-mag, +mag]; mag = 0 yields 0.
    function automatic logic signed [TORQUE_W-1:0] sat_torque(
        input logic signed [TORQUE_W:0] v,
        input logic [TORQUE_W-2:0]      mag
    );
        logic signed [TORQUE_W:0] hi;
        logic signed [TORQUE_W:0] lo;
        logic signed [TORQUE_W:0] r;
        hi = $signed({2'b00, mag});
        lo = -hi;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return 16'(r);
    endfunction

    // Magnitude of a saturated torque; callers guarantee v != -32768.
    function automatic logic [TORQUE_W-2:0] abs_torque(input logic signed [TORQUE_W-1:0] v);
        logic [TORQUE_W-1:0] a;
        a = v[TORQUE_W-1] ? 16'(-v) : 16'(v);
        return 15'(a);
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running PWM counter, period strobe, magnitude latch and registered compare
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic        duty_clr,
    input  logic [14:0] mag_in,
    output logic        pb,
    output logic        pwm_out
);

    localparam int FRAC = 15 - PWM_BITS;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [14:0]         mag_reg;
    logic [14:0]         cnt_scaled;

    assign pb = (pwm_cnt == {PWM_BITS{1'b1}});

    // cnt < mag[14:FRAC] is evaluated as (cnt:all-ones) < mag so every magnitude bit is kept.
    assign cnt_scaled = (15'(pwm_cnt) << FRAC) | ~(15'h7FFF << FRAC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            mag_reg <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (duty_clr) begin
                mag_reg <= '0;
            end else if (pb) begin
                mag_reg <= mag_in;
            end
            pwm_out <= gate && (cnt_scaled < mag_reg);
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - torque command saturation, slew, reversal dead period, watchdog and PWM drive
module motor_pwm_driver
    import reflex_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [TORQUE_W-1:0]        cmd_in,
    input  logic                       cmd_valid,
    input  logic                       override_status,
    input  logic [15:0]                slew_step,
    input  logic [14:0]                max_mag,
    output logic                       pwm_out,
    output logic                       dir_out,
    output logic                       brake_out,
    output logic signed [TORQUE_W-1:0] cmd_applied,
    output logic                       fault_wdog,
    output logic [1:0]                 drv_state
);

    localparam logic [23:0] WDOG_LIM = 24'(WDOG_CYCLES);

    drv_state_e                 state, state_nxt;
    logic signed [TORQUE_W-1:0] target, cmd_sat, target_eff, slew_val, applied_nxt;
    logic                       dir_nxt;
    logic [23:0]                wdog_cnt;
    logic                       pb, wdog_exp, reversal;
    logic [16:0]                t17, a17, diff, adiff, step17, raw;
    logic [14:0]                mag_nxt;

    assign cmd_sat    = sat_torque($signed({cmd_in[TORQUE_W-1], cmd_in}), max_mag);
    assign target_eff = cmd_valid ? cmd_sat : target;
    assign wdog_exp   = (wdog_cnt >= WDOG_LIM) && !cmd_valid;

    // Slew candidate for this period boundary, computed at 17 bits to avoid overflow.
    always_comb begin
        t17    = {target_eff[TORQUE_W-1], target_eff};
        a17    = {cmd_applied[TORQUE_W-1], cmd_applied};
        diff   = t17 - a17;
        adiff  = diff[16] ? (17'd0 - diff) : diff;
        step17 = {1'b0, slew_step};
        if (override_status || (adiff <= step17)) begin
            raw = t17;
        end else if (diff[16]) begin
            raw = a17 - step17;
        end else begin
            raw = a17 + step17;
        end
        slew_val = sat_torque($signed(raw), max_mag);
        reversal = (slew_val != 0) && (cmd_applied != 0) &&
                   (slew_val[TORQUE_W-1] != cmd_applied[TORQUE_W-1]);
    end

    always_comb begin
        state_nxt   = state;
        applied_nxt = cmd_applied;
        dir_nxt     = dir_out;
        case (state)
            DRV_IDLE: begin
                if (enable && pb) begin
                    state_nxt = DRV_RUN;
                end
            end
            DRV_RUN, DRV_DEADTIME: begin
                if (wdog_exp) begin
                    state_nxt   = DRV_FAULT;
                    applied_nxt = '0;
                end else if (pb) begin
                    if (state == DRV_RUN && reversal) begin
                        state_nxt   = DRV_DEADTIME;
                        applied_nxt = '0;
                    end else begin
                        state_nxt   = DRV_RUN;
                        applied_nxt = slew_val;
                        dir_nxt     = slew_val[TORQUE_W-1];
                    end
                end
            end
            DRV_FAULT: begin
                applied_nxt = '0;
                if (enable && cmd_valid) begin
                    state_nxt = DRV_RUN;
                end
            end
        endcase
        if (!enable) begin
            state_nxt   = DRV_IDLE;
            applied_nxt = '0;
            dir_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= DRV_IDLE;
            cmd_applied <= '0;
            dir_out     <= 1'b0;
            target      <= '0;
            wdog_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            cmd_applied <= applied_nxt;
            dir_out     <= dir_nxt;
            if (cmd_valid) begin
                target <= cmd_sat;
            end
            if (cmd_valid || !(state == DRV_RUN || state == DRV_DEADTIME)) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != 24'hFF_FFFF) begin
                wdog_cnt <= wdog_cnt + 24'd1;
            end
        end
    end

    assign mag_nxt    = abs_torque(applied_nxt);
    assign brake_out  = (state == DRV_FAULT);
    assign fault_wdog = (state == DRV_FAULT);
    assign drv_state  = state;

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk      (clk),
        .rst      (rst),
        .gate     (state_nxt == DRV_RUN),
        .duty_clr ((state_nxt == DRV_IDLE) || (state_nxt == DRV_FAULT)),
        .mag_in   (mag_nxt),
        .pb       (pb),
        .pwm_out  (pwm_out)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - directed, table-driven bench for motor_pwm_driver
module tb_motor_pwm_driver;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [15:0]        cmd_in;
    logic               cmd_valid;
    logic               override_status;
    logic [15:0]        slew_step;
    logic [14:0]        max_mag;
    logic               pwm_out;
    logic               dir_out;
    logic               brake_out;
    logic signed [15:0] cmd_applied;
    logic               fault_wdog;
    logic [1:0]         drv_state;

    logic [7:0]         tb_cnt;
    int                 checks = 0;
    int                 errors = 0;

    typedef struct {
        int cmd;
        bit ovr;
        int mag;
        int step;
        int exp_app;
        bit exp_dir;
        int exp_state;
        int exp_high;
    } vec_t;

    vec_t vq[$];

    motor_pwm_driver #(
        .PWM_BITS    (8),
        .WDOG_CYCLES (1000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .cmd_in          (cmd_in),
        .cmd_valid       (cmd_valid),
        .override_status (override_status),
        .slew_step       (slew_step),
        .max_mag         (max_mag),
        .pwm_out         (pwm_out),
        .dir_out         (dir_out),
        .brake_out       (brake_out),
        .cmd_applied     (cmd_applied),
        .fault_wdog      (fault_wdog),
        .drv_state       (drv_state)
    );

    always #5 clk = ~clk;

    // Independent copy of the PWM counter position.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cnt <= 8'd0;
        else      tb_cnt <= tb_cnt + 8'd1;
    end

    function automatic vec_t mk(int cmd, bit ovr, int mag, int step,
                                int exp_app, bit exp_dir, int exp_state, int exp_high);
        vec_t v;
        v.cmd = cmd; v.ovr = ovr; v.mag = mag; v.step = step;
        v.exp_app = exp_app; v.exp_dir = exp_dir; v.exp_state = exp_state; v.exp_high = exp_high;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic goto_cnt(input int v);
        int n = 0;
        while (int'(tb_cnt) != v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (int'(tb_cnt) != v) begin
            errors++;
            $display("FAIL goto_cnt: got %0d expected %0d", tb_cnt, v);
        end
    endtask

    // One full period from cnt 0: keep-alive command at cnt 100, count pwm highs, check after the PB.
    task automatic run_row(input vec_t v, input int idx);
        int highs = 0;
        cmd_in          = 16'(v.cmd);
        override_status = v.ovr;
        max_mag         = 15'(v.mag);
        slew_step       = 16'(v.step);
        for (int i = 0; i < 256; i++) begin
            cmd_valid = (tb_cnt == 8'd100);
            if (pwm_out) highs++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk($sformatf("row%0d applied", idx), int'(cmd_applied), v.exp_app);
        chk($sformatf("row%0d dir", idx), int'(dir_out), int'(v.exp_dir));
        chk($sformatf("row%0d state", idx), int'(drv_state), v.exp_state);
        chk($sformatf("row%0d pwm_high", idx), highs, v.exp_high);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; cmd_in = '0; cmd_valid = 1'b0;
        override_status = 1'b0; slew_step = '0; max_mag = '0;

        vq.push_back(mk(  5000, 0, 32767, 1000,     0, 0, 1,  0));
        vq.push_back(mk(  5000, 0, 32767, 1000,  1000, 0, 1,  0));
        vq.push_back(mk(  5000, 0, 32767, 1000,  2000, 0, 1,  7));
        vq.push_back(mk(  5000, 0, 32767, 1000,  3000, 0, 1, 15));
        vq.push_back(mk(  5000, 0, 32767, 1000,  4000, 0, 1, 23));
        vq.push_back(mk(  5000, 0, 32767, 1000,  5000, 0, 1, 31));
        vq.push_back(mk(  5000, 0, 32767, 1000,  5000, 0, 1, 39));
        vq.push_back(mk( -8000, 1, 32767, 1000,     0, 0, 2, 39));
        vq.push_back(mk( -8000, 1, 32767, 1000, -8000, 1, 1,  0));
        vq.push_back(mk( -8000, 1, 32767, 1000, -8000, 1, 1, 62));
        vq.push_back(mk( 20000, 1,  4096, 1000,     0, 1, 2, 62));
        vq.push_back(mk( 20000, 1,  4096, 1000,  4096, 0, 1,  0));
        vq.push_back(mk( 20000, 1,  4096, 1000,  4096, 0, 1, 32));
        vq.push_back(mk(-32768, 1,  4096, 1000,     0, 0, 2, 32));
        vq.push_back(mk(-32768, 1,  4096, 1000, -4096, 1, 1,  0));
        vq.push_back(mk(-32768, 1,  4096, 1000, -4096, 1, 1, 32));
        vq.push_back(mk(     0, 0,  4096,    0, -4096, 1, 1, 32));
        vq.push_back(mk( -3000, 0,  4096,  500, -3596, 1, 1, 32));
        vq.push_back(mk( -3000, 0,  4096,  500, -3096, 1, 1, 28));
        vq.push_back(mk( -3000, 0,  4096,  500, -3000, 1, 1, 24));
        vq.push_back(mk(  1000, 0,  4096, 5000,     0, 1, 2, 23));
        vq.push_back(mk(  1000, 0,  4096, 5000,  1000, 0, 1,  0));
        vq.push_back(mk(  1000, 0,     0, 5000,     0, 0, 1,  7));

        repeat (3) @(negedge clk);
        chk("reset pwm_out", int'(pwm_out), 0);
        chk("reset applied", int'(cmd_applied), 0);
        chk("reset state", int'(drv_state), 0);
        chk("reset brake", int'(brake_out), 0);
        chk("reset fault", int'(fault_wdog), 0);
        rst = 1'b1;
        enable = 1'b1;

        foreach (vq[i]) run_row(vq[i], i);

        // cmd_valid on the PB cycle feeds that PB's slew.
        max_mag = 15'd32767; slew_step = 16'd4000; override_status = 1'b0; cmd_in = 16'd3000;
        goto_cnt(255);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pb_cmd applied", int'(cmd_applied), 3000);
        chk("pb_cmd dir", int'(dir_out), 0);

        // enable drop mid-period, then re-enable waits for the PB.
        goto_cnt(10);
        chk("pre_disable pwm", int'(pwm_out), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("disable pwm", int'(pwm_out), 0);
        chk("disable applied", int'(cmd_applied), 0);
        chk("disable state", int'(drv_state), 0);
        chk("disable dir", int'(dir_out), 0);
        enable = 1'b1;
        goto_cnt(255);
        chk("reenable before pb", int'(drv_state), 0);
        @(negedge clk);
        chk("reenable after pb", int'(drv_state), 1);

        // Watchdog: a command on the expiry cycle wins, the next expiry faults.
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (1000) @(negedge clk);
        chk("wdog expiry cycle state", int'(drv_state), 1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("wdog cmd wins", int'(drv_state), 1);
        repeat (1000) @(negedge clk);
        chk("wdog not yet", int'(drv_state), 1);
        @(negedge clk);
        chk("wdog state", int'(drv_state), 3);
        chk("wdog fault", int'(fault_wdog), 1);
        chk("wdog brake", int'(brake_out), 1);
        chk("wdog pwm", int'(pwm_out), 0);
        chk("wdog applied", int'(cmd_applied), 0);

        // Fault recovery on the cycle after a command; applied ramps from 0.
        slew_step = 16'd500;
        goto_cnt(20);
        cmd_in = 16'd2000;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("recover state", int'(drv_state), 1);
        chk("recover brake", int'(brake_out), 0);
        chk("recover fault", int'(fault_wdog), 0);
        chk("recover applied", int'(cmd_applied), 0);
        goto_cnt(0);
        chk("recover ramp", int'(cmd_applied), 500);

        // Asynchronous reset with pwm_out high.
        goto_cnt(2);
        chk("pre_reset pwm", int'(pwm_out), 1);
        rst = 1'b0;
        #1;
        chk("async pwm", int'(pwm_out), 0);
        chk("async applied", int'(cmd_applied), 0);
        chk("async state", int'(drv_state), 0);
        chk("async dir", int'(dir_out), 0);
        chk("async brake", int'(brake_out), 0);
        chk("async fault", int'(fault_wdog), 0);
        repeat (3) @(negedge clk);
        chk("reset held state", int'(drv_state), 0);
        chk("reset held pwm", int'(pwm_out), 0);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Downstream stage of the reflex system. Consumes the gated signed torque command and its override flag, and applies saturation and per-period slew limiting. Enforces a dead period on direction reversal and a command watchdog. Converts the result into a sign/magnitude PWM drive for the motor bridge: pwm_out, dir_out, brake_out.

Parameters:
PWM_BITS, 8, PWM counter width; period = 2^PWM_BITS clk cycles.
WDOG_CYCLES, 65535, cycles without cmd_valid before watchdog fault (1..2^24-1).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
enable  input  1  drive enable; 0 forces IDLE.
cmd_in  input  16  signed torque command (final_command of reflex system).
cmd_valid  input  1  one-cycle strobe; cmd_in captured as target.
override_status  input  1  reflex lock active; bypasses slew limit.
slew_step  input  16  unsigned max |change| of applied per period.
max_mag  input  15  unsigned saturation magnitude.
pwm_out  output  1  PWM drive, registered.
dir_out  output  1  0 = forward (applied >= 0), 1 = reverse.
brake_out  output  1  bridge brake, high only in FAULT.
cmd_applied  output  16  signed command currently driving PWM.
fault_wdog  output  1  high while in FAULT.
drv_state  output  2  0 IDLE, 1 RUN, 2 DEADTIME, 3 FAULT.

Behaviour:
- Reset (rst = 0, async) values: pwm_out 0, dir_out 0, brake_out 0, cmd_applied 0, fault_wdog 0, drv_state IDLE, target 0, pwm_cnt 0, watchdog counter 0.
- Target capture: on cmd_valid, target <= sat(cmd_in).
  - sat clamps to [-max_mag, +max_mag]; -32768 clamps to -max_mag.
  - max_mag = 0 forces target 0.
- pwm_cnt is free-running, 0..2^PWM_BITS-1, and wraps. The cycle with pwm_cnt = max is the period boundary (PB).
- duty = |cmd_applied|[14:15-PWM_BITS], latched at PB for the next period.
- pwm_out registered: pwm_out = 1 in the cycle after pwm_cnt < duty_reg is true, and only in RUN. Duty 0 gives constant low.
- Slew, evaluated at PB in RUN:
  - override_status = 1: next = target.
  - Otherwise next = target if |target - applied| <= slew_step, else applied ± slew_step toward target.
  - Arithmetic at 17 bits signed; result stays within ±max_mag.
- Reversal: if sign(next) differs from sign(applied), both nonzero, then:
  - applied <= 0 and move to DEADTIME.
  - DEADTIME lasts one full period: pwm_out 0, dir_out held.
  - At the next PB: dir_out <= new sign, slew resumes from 0, return to RUN.
  - The reversal rule applies with override too.
- dir_out changes only at PB.
- FSM transitions:
  - IDLE -> RUN when enable = 1, synchronous to the next PB.
  - Any state -> IDLE when enable = 0, next cycle. On entry: pwm_out 0, cmd_applied 0, dir_out 0.
  - RUN/DEADTIME -> FAULT when the watchdog counter reaches WDOG_CYCLES.
  - FAULT: pwm_out 0, brake_out 1, cmd_applied 0, fault_wdog 1.
  - FAULT -> RUN on the cycle after a cmd_valid with enable = 1. brake_out and fault_wdog drop that cycle; applied restarts at 0.
  - enable = 0 has priority over FAULT.
- Watchdog: clears on cmd_valid or outside RUN/DEADTIME, otherwise increments, saturating.
- Simultaneous events:
  - cmd_valid on a PB cycle: the new target is used for that PB's slew.
  - cmd_valid on the watchdog-expiry cycle: the cmd wins, no fault.
- Target persists across DEADTIME. slew_step = 0 without override freezes applied.

Decomposition:
- Shared package reflex_pkg:
  - drv_state encodings.
  - TORQUE_W = 16.
  - Saturate/absolute-value functions, reusable by policy_gate.
- One natural sub-module, pwm_gen: counter, PB strobe, duty latch, registered compare.
- FSM, slew and watchdog stay in the top.

Test Plan:
1. rst = 0 mid-period with pwm_out high -> all outputs 0 and drv_state 0 immediately (async), held until release.
2. PWM_BITS = 8, enable = 1, slew_step = 1000, max_mag = 32767, cmd 5000 -> applied 1000, 2000, 3000, 4000, 5000 on successive PBs; duty 7, 15, 23, 31, 39; pwm_out high 39 of 256 cycles.
3. From applied 5000, cmd -8000 with override_status = 1 -> applied 0 and DEADTIME for 256 cycles with pwm_out 0, then applied -8000, dir_out 1, duty 62.
4. max_mag = 4096, cmd 20000 with override -> applied 4096, duty 32; cmd -32768 -> applied -4096 after dead period.
5. WDOG_CYCLES = 1000, no cmd_valid for 1000 cycles in RUN -> fault_wdog 1, brake_out 1, pwm_out 0, drv_state 3; a cmd_valid of 2000 -> RUN next cycle, applied ramps from 0.
6. enable dropped mid-period -> next cycle pwm_out 0, cmd_applied 0, drv_state 0; re-enable -> RUN at the following PB.
